// File: rtl/sdp_nrdma_eg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_nrdma_eg_pkg                                                          |
// | Shared widths, field offsets and FSM encoding for the NRDMA egress unpack |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package sdp_nrdma_eg_pkg;

   localparam int DW       = 256;
   localparam int MW       = 2;
   localparam int CNT_W    = 32;

   localparam int ENTRY_W  = 2*DW + MW;
   localparam int ATOM_W   = DW + 1;

   // Half-valid mask bit positions
   localparam int LO       = 0;
   localparam int HI       = 1;

   // Latency-FIFO entry and atom field offsets
   localparam int DATA_OFS = 0;
   localparam int MASK_OFS = 2*DW;
   localparam int LAST_BIT = DW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // One-hot mask bit for the selected half
   function automatic logic [MW-1:0] half_bit(input logic hi);
      return hi ? MW'(1 << HI) : MW'(1 << LO);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_nrdma_eg_lat_unpack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_nrdma_eg_lat_unpack_if                                                |
// | Valid/ready payload stream used for both latency-FIFO and atom sides      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface sdp_nrdma_eg_lat_unpack_if
   import sdp_nrdma_eg_pkg::*;
#(
   parameter int W = ENTRY_W
) ();

   logic         pvld;
   logic         prdy;
   logic [W-1:0] pd;

   modport master (
      output pvld,
      output pd,
      input  prdy
   );

   modport slave (
      input  pvld,
      input  pd,
      output prdy
   );

endinterface
`default_nettype wire

// File: rtl/sdp_nrdma_eg_lat_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdp_nrdma_eg_lat_unpack                                                   |
// | Splits 512-bit latency-FIFO entries into 256-bit atoms, counts atoms per  |
// | layer, tags the last one and returns one FIFO credit per entry.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sdp_nrdma_eg_lat_unpack
   import sdp_nrdma_eg_pkg::*;
(
   input  logic                        nvdla_core_clk_mgated,
   input  logic                        nvdla_core_rstn,
   input  logic                        op_en,
   input  logic [CNT_W-1:0]            reg2dp_atom_total,
   sdp_nrdma_eg_lat_unpack_if.slave    lat_rd,
   sdp_nrdma_eg_lat_unpack_if.master   unpack,
   output logic                        dma_rd_cdt_lat_fifo_pop,
   output logic                        eg_done
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    total_q, total_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [2*DW-1:0]     data_q,  data_d;
   logic [MW-1:0]       mask_q,  mask_d;
   logic                full_q,  full_d;
   logic                pop_q,   pop_d;
   logic                done_q,  done_d;

   logic                sel_hi;
   logic                atom_last;
   logic                atom_acc;
   logic                abort;
   logic                entry_release;
   logic                lat_load;
   logic [MW-1:0]       mask_after;

   // Low half always goes first when both halves are pending
   assign sel_hi    = ~mask_q[LO];
   assign atom_last = (cnt_q == (total_q - CNT_W'(1)));

   assign unpack.pvld = (state_q == RUN) && full_q && (mask_q != '0);
   assign unpack.pd   = {atom_last,
                         sel_hi ? data_q[DATA_OFS+DW +: DW] : data_q[DATA_OFS +: DW]};

   assign atom_acc   = unpack.pvld && unpack.prdy;
   assign abort      = (state_q == RUN) && !op_en;
   assign mask_after = atom_acc ? (mask_q & ~half_bit(sel_hi)) : mask_q;

   // An entry leaves the buffer once nothing is pending, on the last atom
   // (dropping any remaining half) or when the layer is aborted.
   assign entry_release = full_q &&
                          (abort || (mask_after == '0) || (atom_acc && atom_last));

   // No new entry is taken while the layer is being torn down
   assign lat_rd.prdy = (state_q == RUN) && op_en &&
                        (!full_q || (atom_acc && (mask_after == '0) && !atom_last));
   assign lat_load    = lat_rd.prdy && lat_rd.pvld;

   assign dma_rd_cdt_lat_fifo_pop = pop_q;
   assign eg_done                 = done_q;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      mask_d = mask_after;
      pop_d  = entry_release;

      if (lat_load) begin
         full_d = 1'b1;
         data_d = lat_rd.pd[DATA_OFS +: 2*DW];
         mask_d = lat_rd.pd[MASK_OFS +: MW];
      end else if (entry_release) begin
         full_d = 1'b0;
         mask_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      total_d = total_q;
      cnt_d   = atom_acc ? (cnt_q + CNT_W'(1)) : cnt_q;

      case (state_q)
         IDLE: begin
            if (op_en) begin
               total_d = reg2dp_atom_total;
               cnt_d   = '0;
               state_d = (reg2dp_atom_total == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (!op_en) begin
               state_d = IDLE;
            end else if (atom_acc && atom_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!op_en) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE) && (state_q != DONE);
   end

   always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= IDLE;
         total_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         full_q  <= 1'b0;
         pop_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         total_q <= total_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         full_q  <= full_d;
         pop_q   <= pop_d;
         done_q  <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdp_nrdma_eg_lat_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdp_nrdma_eg_lat_unpack                                                |
// | Directed bench for the NRDMA egress latency-FIFO unpacker                 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sdp_nrdma_eg_lat_unpack;
   import sdp_nrdma_eg_pkg::*;

   logic             clk   = 1'b0;
   logic             rstn  = 1'b0;
   logic             op_en = 1'b0;
   logic [CNT_W-1:0] total = '0;
   logic             pop;
   logic             done;

   sdp_nrdma_eg_lat_unpack_if #(.W(ENTRY_W)) lat_if ();
   sdp_nrdma_eg_lat_unpack_if #(.W(ATOM_W))  up_if ();

   sdp_nrdma_eg_lat_unpack dut (
      .nvdla_core_clk_mgated   (clk),
      .nvdla_core_rstn         (rstn),
      .op_en                   (op_en),
      .reg2dp_atom_total       (total),
      .lat_rd                  (lat_if),
      .unpack                  (up_if),
      .dma_rd_cdt_lat_fifo_pop (pop),
      .eg_done                 (done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_pop  = 0;
   int n_done = 0;

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (pop)  n_pop++;
      if (done) n_done++;
   end

   logic [ENTRY_W-1:0] ent [8];
   logic [ATOM_W-1:0]  got [8];
   int                 got_n;

   function automatic logic [ENTRY_W-1:0] mk(input int i, input logic [MW-1:0] m);
      logic [31:0] lo;
      logic [31:0] hi;
      lo = 32'hA0A0_0000 + 32'(i);
      hi = 32'hB0B0_0000 + 32'(i);
      return {m, {8{hi}}, {8{lo}}};
   endfunction

   function automatic logic [ATOM_W-1:0] at(input logic last, input logic hi, input int i);
      logic [31:0] tag;
      tag = hi ? (32'hB0B0_0000 + 32'(i)) : (32'hA0A0_0000 + 32'(i));
      return {last, {8{tag}}};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
   endtask

   task automatic chkd(input string tag, input logic [ATOM_W-1:0] obs, input logic [ATOM_W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers ent[0..n_ent-1], collects atoms, stops one cycle after eg_done
   task automatic run_layer(input int n_ent, input int tot, input bit stall, input int max_cyc);
      int idx;
      int cyc;
      int d0;
      idx   = 0;
      cyc   = 0;
      d0    = n_done;
      got_n = 0;
      total = CNT_W'(tot);
      op_en = 1'b1;
      while (n_done == d0 && cyc < max_cyc) begin
         lat_if.pvld = (idx < n_ent);
         lat_if.pd   = (idx < n_ent) ? ent[idx] : '0;
         up_if.prdy  = !stall || ((cyc % 3) != 2);
         #1;
         if (lat_if.pvld && lat_if.prdy) idx++;
         if (up_if.pvld && up_if.prdy && got_n < 8) begin
            got[got_n] = up_if.pd;
            got_n++;
         end
         tick();
         cyc++;
      end
      chk1("layer_done_in_time", (n_done != d0), 1'b1);
      lat_if.pvld = 1'b0;
      up_if.prdy  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int d0;

      lat_if.pvld = 1'b0;
      lat_if.pd   = '0;
      up_if.prdy  = 1'b0;

      // Reset state
      repeat (3) tick();
      chk1("rst_unpack_pvld", up_if.pvld, 1'b0);
      chk1("rst_lat_prdy", lat_if.prdy, 1'b0);
      chk1("rst_pop", pop, 1'b0);
      chk1("rst_done", done, 1'b0);
      chkd("rst_unpack_pd", up_if.pd, '0);
      rstn = 1'b1;
      tick();

      // Streaming: two mask-11 entries, total 4
      p0 = n_pop;
      op_en = 1'b1; total = 4; up_if.prdy = 1'b1;
      #1; chk1("idle_lat_prdy", lat_if.prdy, 1'b0);
      tick();
      lat_if.pvld = 1'b1; lat_if.pd = mk(0, 2'b11);
      #1; chk1("run_prdy_empty", lat_if.prdy, 1'b1);
      chk1("no_atom_before_load", up_if.pvld, 1'b0);
      tick();
      lat_if.pd = mk(1, 2'b11);
      #1; chk1("first_atom_latency", up_if.pvld, 1'b1);
      chkd("s_atom0", up_if.pd, at(0, 0, 0));
      chk1("prdy_mid_entry", lat_if.prdy, 1'b0);
      tick();
      #1; chkd("s_atom1", up_if.pd, at(0, 1, 0));
      chk1("prdy_back_to_back", lat_if.prdy, 1'b1);
      tick();
      lat_if.pvld = 1'b0;
      #1; chk1("s_pop_entry0", pop, 1'b1);
      chkd("s_atom2", up_if.pd, at(0, 0, 1));
      tick();
      #1; chkd("s_atom3_last", up_if.pd, at(1, 1, 1));
      chk1("prdy_on_last", lat_if.prdy, 1'b0);
      chk1("s_no_merge_pop", pop, 1'b0);
      tick();
      #1; chk1("s_eg_done", done, 1'b1);
      chk1("s_pop_entry1", pop, 1'b1);
      chk1("s_done_no_pvld", up_if.pvld, 1'b0);
      tick();
      #1; chk1("s_eg_done_single", done, 1'b0);
      chki("s_credits", n_pop - p0, 2);
      op_en = 1'b0; up_if.prdy = 1'b0;
      tick(); tick();

      // Masks 01, 10, 00, 11 with stalls, total 4
      p0 = n_pop;
      ent[0] = mk(0, 2'b01); ent[1] = mk(1, 2'b10);
      ent[2] = mk(2, 2'b00); ent[3] = mk(3, 2'b11);
      run_layer(4, 4, 1'b1, 200);
      chki("m_atom_count", got_n, 4);
      chkd("m_atom0", got[0], at(0, 0, 0));
      chkd("m_atom1", got[1], at(0, 1, 1));
      chkd("m_atom2", got[2], at(0, 0, 3));
      chkd("m_atom3", got[3], at(1, 1, 3));
      chki("m_credits", n_pop - p0, 4);
      op_en = 1'b0;
      tick(); tick();

      // Backpressure on a mask-11 entry, total 2
      p0 = n_pop;
      op_en = 1'b1; total = 2; up_if.prdy = 1'b0;
      lat_if.pvld = 1'b1; lat_if.pd = mk(5, 2'b11);
      tick(); tick();
      lat_if.pvld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1; chkd("bp_pd_hold", up_if.pd, at(0, 0, 5));
         chk1("bp_lat_prdy", lat_if.prdy, 1'b0);
         tick();
      end
      chki("bp_no_credit", n_pop - p0, 0);
      up_if.prdy = 1'b1;
      tick();
      #1; chkd("bp_hi_last", up_if.pd, at(1, 1, 5));
      chki("bp_no_credit_half", n_pop - p0, 0);
      tick();
      #1; chk1("bp_done", done, 1'b1);
      chk1("bp_pop", pop, 1'b1);
      op_en = 1'b0; up_if.prdy = 1'b0;
      tick(); tick();

      // Early last: total 3 over two mask-11 entries
      p0 = n_pop;
      ent[0] = mk(0, 2'b11); ent[1] = mk(1, 2'b11);
      run_layer(2, 3, 1'b0, 100);
      chki("e_atom_count", got_n, 3);
      chkd("e_atom1", got[1], at(0, 1, 0));
      chkd("e_atom2_last", got[2], at(1, 0, 1));
      chki("e_credits", n_pop - p0, 2);
      lat_if.pvld = 1'b1; lat_if.pd = mk(4, 2'b11);
      #1; chk1("e_done_lat_prdy", lat_if.prdy, 1'b0);
      chk1("e_done_pvld", up_if.pvld, 1'b0);
      lat_if.pvld = 1'b0; op_en = 1'b0;
      tick(); tick();

      // Abort after one atom
      op_en = 1'b1; total = 4; up_if.prdy = 1'b0;
      lat_if.pvld = 1'b1; lat_if.pd = mk(6, 2'b11);
      tick(); tick();
      lat_if.pvld = 1'b0; up_if.prdy = 1'b1;
      #1; chkd("a_atom0", up_if.pd, at(0, 0, 6));
      tick();
      op_en = 1'b0; up_if.prdy = 1'b0;
      p0 = n_pop; d0 = n_done;
      tick();
      #1; chk1("a_pop", pop, 1'b1);
      chk1("a_pvld_cleared", up_if.pvld, 1'b0);
      chk1("a_lat_prdy", lat_if.prdy, 1'b0);
      tick(); tick();
      chki("a_credits", n_pop - p0, 1);
      chki("a_no_done", n_done - d0, 0);

      // Zero-atom layer
      total = 0; op_en = 1'b1;
      lat_if.pvld = 1'b1; lat_if.pd = mk(7, 2'b01);
      #1; chk1("z_lat_prdy_idle", lat_if.prdy, 1'b0);
      tick();
      #1; chk1("z_done", done, 1'b1);
      chk1("z_lat_prdy", lat_if.prdy, 1'b0);
      chk1("z_no_atom", up_if.pvld, 1'b0);
      tick();
      #1; chk1("z_done_single", done, 1'b0);
      chk1("z_lat_prdy_hold", lat_if.prdy, 1'b0);
      op_en = 1'b0; lat_if.pvld = 1'b0;
      tick(); tick();

      // Reset while an entry is held
      op_en = 1'b1; total = 4; up_if.prdy = 1'b0;
      lat_if.pvld = 1'b1; lat_if.pd = mk(8, 2'b11);
      tick(); tick();
      lat_if.pvld = 1'b0;
      #1; chk1("r_entry_held", up_if.pvld, 1'b1);
      p0 = n_pop;
      rstn = 1'b0;
      #1; chk1("r_pvld", up_if.pvld, 1'b0);
      chk1("r_lat_prdy", lat_if.prdy, 1'b0);
      chkd("r_pd", up_if.pd, '0);
      chk1("r_pop", pop, 1'b0);
      op_en = 1'b0;
      tick();
      rstn = 1'b1;
      tick(); tick(); tick();
      chki("r_no_credit", n_pop - p0, 0);
      chk1("r_idle_pvld", up_if.pvld, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
